// File: rtl/interp_sample_gen_pkg.sv
// Shared channel-estimation constants for the pilot interpolator:
// operand widths, FSM encoding and span length.
package interp_sample_gen_pkg;

  localparam int CE_BASE_W = 16;
  localparam int CE_REG1   = 17;
  localparam int CE_REG2   = 18;
  localparam int CE_REG3   = 20;
  localparam int CE_OUT_W  = 21;

  localparam int K_W = 3;

  localparam logic [K_W-1:0] K_LAST = 3'd5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

endpackage

// File: rtl/interp_sample_gen_add.sv
// Sign-extending two-operand adder with a per-k operand mux.
// k3/k4 reuse the stored base+2E partial so 2E is applied as given.
module interp_add
  import interp_sample_gen_pkg::*;
#(
  parameter int BASE_W = CE_BASE_W,
  parameter int REG1   = CE_REG1,
  parameter int REG2   = CE_REG2,
  parameter int REG3   = CE_REG3,
  parameter int OUT_W  = CE_OUT_W
) (
  input  logic [K_W-1:0]    k,
  input  logic [BASE_W-1:0] base,
  input  logic [REG1-1:0]   e,
  input  logic [REG2-1:0]   e2,
  input  logic [REG3-1:0]   e5,
  input  logic [OUT_W-1:0]  part,
  output logic [OUT_W-1:0]  sum
);

  logic [OUT_W-1:0] sb;
  logic [OUT_W-1:0] se;
  logic [OUT_W-1:0] se2;
  logic [OUT_W-1:0] se5;
  logic [OUT_W-1:0] a;
  logic [OUT_W-1:0] b;

  assign sb  = {{(OUT_W-BASE_W){base[BASE_W-1]}}, base};
  assign se  = {{(OUT_W-REG1){e[REG1-1]}}, e};
  assign se2 = {{(OUT_W-REG2){e2[REG2-1]}}, e2};
  assign se5 = {{(OUT_W-REG3){e5[REG3-1]}}, e5};

  // Pick the two addends for the sample at position k.
  always_comb begin
    a = sb;
    b = '0;
    unique case (k)
      3'd1: b = se;
      3'd2: b = se2;
      3'd3: begin
        a = part;
        b = se;
      end
      3'd4: begin
        a = part;
        b = se2;
      end
      3'd5: b = se5;
      default: b = '0;
    endcase
  end

  assign sum = a + b;

endmodule

// File: rtl/interp_sample_gen.sv
// Emits one six-sample pilot interpolation span per start,
// with a valid/ready output and registered samples.
module interp_sample_gen
  import interp_sample_gen_pkg::*;
#(
  parameter int BASE_W = CE_BASE_W,
  parameter int REG1   = CE_REG1,
  parameter int REG2   = CE_REG2,
  parameter int REG3   = CE_REG3,
  parameter int OUT_W  = CE_OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BASE_W-1:0] base,
  input  logic [REG1-1:0]   reg_E,
  input  logic [REG2-1:0]   reg_2E,
  input  logic [REG3-1:0]   reg_5E,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_sample,
  output logic              out_last,
  output logic              busy
);

  logic [0:0]        state;
  logic [K_W-1:0]    k;
  logic [K_W-1:0]    k_nxt;
  logic [BASE_W-1:0] cap_base;
  logic [REG1-1:0]   cap_e;
  logic [REG2-1:0]   cap_2e;
  logic [REG3-1:0]   cap_5e;
  logic [OUT_W-1:0]  part;
  logic [OUT_W-1:0]  sum;
  logic              xfer;

  assign k_nxt = k + 3'd1;
  assign xfer  = out_valid & out_ready;
  assign busy  = (state == ST_EMIT);

  interp_add #(
    .BASE_W(BASE_W),
    .REG1  (REG1),
    .REG2  (REG2),
    .REG3  (REG3),
    .OUT_W (OUT_W)
  ) u_add (
    .k   (k_nxt),
    .base(cap_base),
    .e   (cap_e),
    .e2  (cap_2e),
    .e5  (cap_5e),
    .part(part),
    .sum (sum)
  );

  // Span FSM: capture on start, advance k on each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      k          <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_sample <= '0;
      cap_base   <= '0;
      cap_e      <= '0;
      cap_2e     <= '0;
      cap_5e     <= '0;
      part       <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            cap_base   <= base;
            cap_e      <= reg_E;
            cap_2e     <= reg_2E;
            cap_5e     <= reg_5E;
            k          <= '0;
            state      <= ST_EMIT;
            out_valid  <= 1'b1;
            out_last   <= 1'b0;
            out_sample <= {{(OUT_W-BASE_W){base[BASE_W-1]}}, base};
          end
        end
        ST_EMIT: begin
          if (xfer) begin
            if (k == K_LAST) begin
              state     <= ST_IDLE;
              k         <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              k          <= k_nxt;
              out_sample <= sum;
              out_last   <= (k_nxt == K_LAST);
              if (k_nxt == 3'd2) part <= sum;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interp_sample_gen.sv
// Self-checking bench for interp_sample_gen against a
// plain-arithmetic span model.
module tb_interp_sample_gen;
  import interp_sample_gen_pkg::*;

  localparam int BASE_W = CE_BASE_W;
  localparam int REG1   = CE_REG1;
  localparam int REG2   = CE_REG2;
  localparam int REG3   = CE_REG3;
  localparam int OUT_W  = CE_OUT_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [BASE_W-1:0] base;
  logic [REG1-1:0]   reg_E;
  logic [REG2-1:0]   reg_2E;
  logic [REG3-1:0]   reg_5E;
  logic              out_ready;
  logic              out_valid;
  logic [OUT_W-1:0]  out_sample;
  logic              out_last;
  logic              busy;

  int n_pass = 0;
  int n_chk  = 0;
  int exp_s[6];

  interp_sample_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .reg_E     (reg_E),
    .reg_2E    (reg_2E),
    .reg_5E    (reg_5E),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_sample(out_sample),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void model(input int b, input int e,
                                input int e2, input int e5);
    exp_s[0] = b;
    exp_s[1] = b + e;
    exp_s[2] = b + e2;
    exp_s[3] = b + e2 + e;
    exp_s[4] = b + e2 + e2;
    exp_s[5] = b + e5;
  endfunction

  task automatic set_ops(input int b, input int e,
                         input int e2, input int e5);
    base   = BASE_W'(b);
    reg_E  = REG1'(e);
    reg_2E = REG2'(e2);
    reg_5E = REG3'(e5);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    set_ops(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 ||
        out_sample !== '0)
      $display("FAIL reset: valid=%b busy=%b last=%b sample=%0d want 0",
               out_valid, busy, out_last, out_sample);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_span(input string nm, input int b, input int e,
                           input int e2, input int e5);
    model(b, e, e2, e5);
    set_ops(b, e, e2, e5);
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || $signed(out_sample) !== exp_s[i] ||
          out_last !== (i == 5) || busy !== 1'b1)
        $display("FAIL %s k%0d: valid=%b sample=%0d last=%b want 1 %0d %b",
                 nm, i, out_valid, $signed(out_sample), out_last,
                 exp_s[i], (i == 5));
      else n_pass++;
      @(negedge clk);
    end
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s end: valid=%b busy=%b want 0 0",
               nm, out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int held = 0;
    int cyc = 0;
    model(100, 10, 20, 50);
    set_ops(100, 10, 20, 50);
    pulse_start();
    while (idx < 6 && cyc < 40) begin
      out_ready = !(idx == 2 && held < 3);
      n_chk++;
      if (out_valid !== 1'b1 || $signed(out_sample) !== exp_s[idx] ||
          out_last !== (idx == 5))
        $display("FAIL bp k%0d: valid=%b sample=%0d last=%b want 1 %0d %b",
                 idx, out_valid, $signed(out_sample), out_last,
                 exp_s[idx], (idx == 5));
      else n_pass++;
      if (out_ready) idx++;
      else held++;
      cyc++;
      @(negedge clk);
    end
    n_chk++;
    if (idx != 6 || held != 3 || out_valid !== 1'b0)
      $display("FAIL bp count: xfers=%0d held=%0d valid=%b want 6 3 0",
               idx, held, out_valid);
    else n_pass++;
    out_ready = 1'b1;
  endtask

  task automatic test_start_ignored();
    model(100, 10, 20, 50);
    set_ops(100, 10, 20, 50);
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      start = (i == 2 || i == 5);
      base = (i == 2) ? BASE_W'(7) : BASE_W'(100);
      n_chk++;
      if (out_valid !== 1'b1 || $signed(out_sample) !== exp_s[i])
        $display("FAIL ign k%0d: valid=%b sample=%0d want 1 %0d",
                 i, out_valid, $signed(out_sample), exp_s[i]);
      else n_pass++;
      @(negedge clk);
    end
    start = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL ign end: valid=%b busy=%b want 0 0",
               out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_ops(100, 10, 20, 50);
    out_ready = 1'b1;
    pulse_start();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sample !== '0)
      $display("FAIL rstmid: valid=%b busy=%b sample=%0d want 0 0 0",
               out_valid, busy, out_sample);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rstmid idle: valid=%b busy=%b want 0 0",
               out_valid, busy);
    else n_pass++;
    test_span("after_rst", 5, 1, 2, 5);
  endtask

  task automatic test_input_change();
    model(100, 10, 20, 50);
    set_ops(100, 10, 20, 50);
    out_ready = 1'b1;
    pulse_start();
    reg_E = REG1'(99);
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if ($signed(out_sample) !== exp_s[i] || out_valid !== 1'b1)
        $display("FAIL chg k%0d: sample=%0d valid=%b want %0d 1",
                 i, $signed(out_sample), out_valid, exp_s[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [BASE_W-1:0] rb;
    logic [REG1-1:0]   re;
    logic [REG2-1:0]   re2;
    logic [REG3-1:0]   re5;
    int idx;
    int cyc;
    for (int s = 0; s < 20; s++) begin
      rb  = BASE_W'($urandom);
      re  = REG1'($urandom);
      re2 = REG2'($urandom);
      re5 = REG3'($urandom);
      model($signed(rb), $signed(re), $signed(re2), $signed(re5));
      base = rb;
      reg_E = re;
      reg_2E = re2;
      reg_5E = re5;
      out_ready = 1'b1;
      pulse_start();
      base = BASE_W'($urandom);
      reg_5E = REG3'($urandom);
      idx = 0;
      cyc = 0;
      while (idx < 6 && cyc < 60) begin
        out_ready = ($urandom_range(0, 3) != 0);
        n_chk++;
        if (out_valid !== 1'b1 || $signed(out_sample) !== exp_s[idx] ||
            out_last !== (idx == 5))
          $display("FAIL rnd s%0d k%0d: sample=%0d last=%b want %0d %b",
                   s, idx, $signed(out_sample), out_last,
                   exp_s[idx], (idx == 5));
        else n_pass++;
        if (out_ready) idx++;
        cyc++;
        @(negedge clk);
      end
      n_chk++;
      if (idx != 6 || out_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL rnd s%0d end: xfers=%0d valid=%b want 6 0",
                 s, idx, out_valid);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_span("basic", 100, 10, 20, 50);
    test_span("neg", -32768, -1000, -2000, -5000);
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_input_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
